// File: rtl/des_pkg.sv
// DES constant tables and bit-permutation helpers shared by the DES datapaths.
// Vectors are [N-1:0] with DES bit 1 at the MSB, so DES bit n of x is x[N-n].
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } state_e;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // One box per entry, 64 nibbles in row-major order, entry 0 leftmost.
    localparam logic [255:0] SBOX_T [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    localparam logic [1:0] RSH_T [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [63:0] f_ip(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63-i] = x[64-IP_T[i]];
        return r;
    endfunction

    function automatic logic [63:0] f_fp(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63-i] = x[64-FP_T[i]];
        return r;
    endfunction

    function automatic logic [47:0] f_e(input logic [31:0] x);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = x[32-E_T[i]];
        return r;
    endfunction

    function automatic logic [31:0] f_p(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[31-i] = x[32-P_T[i]];
        return r;
    endfunction

    function automatic logic [55:0] f_pc1(input logic [63:0] x);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55-i] = x[64-PC1_T[i]];
        return r;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] x);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = x[56-PC2_T[i]];
        return r;
    endfunction

    function automatic logic [31:0] f_sbox(input logic [47:0] x);
        logic [31:0] r;
        logic [5:0]  six;
        int          idx;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            six = x[47-6*j -: 6];
            idx = {26'd0, six[5], six[0], six[4:1]};
            r[31-4*j -: 4] = SBOX_T[j][255-4*idx -: 4];
        end
        return r;
    endfunction

    function automatic logic [27:0] f_rotr(input logic [27:0] v, input logic [1:0] s);
        logic [27:0] r;
        unique case (s)
            2'd1:    r = {v[0], v[27:1]};
            2'd2:    r = {v[1:0], v[27:2]};
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] f_rsh(input logic [4:0] idx);
        return RSH_T[idx[3:0]];
    endfunction

endpackage

// File: rtl/des_decrypt_iter_round.sv
// One combinational DES decrypt round: rotate C/D right, derive the subkey, Feistel step.
module des_round
    import des_pkg::*;
(
    input  logic [31:0] l_i,
    input  logic [31:0] r_i,
    input  logic [27:0] c_i,
    input  logic [27:0] d_i,
    input  logic [1:0]  shift_i,
    output logic [31:0] l_o,
    output logic [31:0] r_o,
    output logic [27:0] c_o,
    output logic [27:0] d_o
);

    logic [47:0] k;

    // Round 1 shifts by 0, so it sees the PC1 halves directly and yields K16.
    assign c_o = f_rotr(c_i, shift_i);
    assign d_o = f_rotr(d_i, shift_i);
    assign k   = f_pc2({c_o, d_o});
    assign l_o = r_i;
    assign r_o = l_i ^ f_p(f_sbox(f_e(r_i) ^ k));

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor, UNROLL rounds per clock, valid/ready on both sides.
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:1] ciphertext,
    input  logic [64:1] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] plaintext,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [4:0]  rnd_q, rnd_d;
    logic [63:0] pt_q, pt_d;
    logic        accept;

    for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
        logic [31:0] li, ri, lo, ro;
        logic [27:0] ci, di, co, dout;
        if (g == 0) begin : g_first
            assign li = l_q;
            assign ri = r_q;
            assign ci = c_q;
            assign di = d_q;
        end else begin : g_next
            assign li = g_rnd[g-1].lo;
            assign ri = g_rnd[g-1].ro;
            assign ci = g_rnd[g-1].co;
            assign di = g_rnd[g-1].dout;
        end
        des_round u_round (
            .l_i     (li),
            .r_i     (ri),
            .c_i     (ci),
            .d_i     (di),
            .shift_i (f_rsh(rnd_q + 5'(g))),
            .l_o     (lo),
            .r_o     (ro),
            .c_o     (co),
            .d_o     (dout)
        );
    end

    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_ROUND);
    assign plaintext = pt_q;

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        rnd_d   = rnd_q;
        pt_d    = pt_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_ROUND: begin
                l_d   = g_rnd[UNROLL-1].lo;
                r_d   = g_rnd[UNROLL-1].ro;
                c_d   = g_rnd[UNROLL-1].co;
                d_d   = g_rnd[UNROLL-1].dout;
                rnd_d = rnd_q + 5'(UNROLL);
                if (rnd_d == 5'd16) begin
                    state_d = ST_DONE;
                    pt_d    = f_fp({g_rnd[UNROLL-1].ro, g_rnd[UNROLL-1].lo});
                end
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A new block may start from IDLE or straight out of DONE.
        if (accept) begin
            state_d    = ST_ROUND;
            {l_d, r_d} = f_ip(ciphertext);
            {c_d, d_d} = f_pc1(key);
            rnd_d      = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            rnd_q   <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            rnd_q   <= rnd_d;
            pt_q    <= pt_d;
        end
    end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Bench for des_decrypt_iter: known answers, handshake corners, reset abort, round trips.
module tb_des_decrypt_iter;
    import des_pkg::*;

    localparam int NU = 5;

    typedef struct {
        logic [63:0] key;
        logic [63:0] ct;
        logic [63:0] pt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv   [NU];
    logic        ir   [NU];
    logic        ov   [NU];
    logic        ordy [NU];
    logic        bz   [NU];
    logic [63:0] ct   [NU];
    logic [63:0] ky   [NU];
    logic [63:0] pt   [NU];

    int          n_chk = 0;
    int          n_pass = 0;
    int          sel = 0;
    logic [63:0] expq [$];
    vec_t        vt [7];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        des_decrypt_iter #(.UNROLL(1 << g)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (iv[g]),
            .in_ready   (ir[g]),
            .ciphertext (ct[g]),
            .key        (ky[g]),
            .out_valid  (ov[g]),
            .out_ready  (ordy[g]),
            .plaintext  (pt[g]),
            .busy       (bz[g])
        );
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (unit %0d): got %h expected %h", nm, sel, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent encryptor: forward key schedule with left rotations.
    function automatic logic [63:0] enc(input logic [63:0] k, input logic [63:0] p);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [31:0] l, r, t;
        int          sh;
        cd = f_pc1(k);
        c = cd[55:28];
        d = cd[27:0];
        {l, r} = f_ip(p);
        for (int i = 0; i < 16; i++) begin
            sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
            for (int j = 0; j < sh; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            t = r;
            r = l ^ f_p(f_sbox(f_e(r) ^ f_pc2({c, d})));
            l = t;
        end
        return f_fp({r, l});
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ov[sel] === 1'b1 && ordy[sel] === 1'b1) begin
            if (expq.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected (unit %0d): got %h expected none", sel, pt[sel]);
            end else begin
                chk("sb_plaintext", pt[sel], expq.pop_front());
            end
        end
    end

    task automatic wait_ov(input int s, input int lat);
        int n;
        n = 0;
        while (ov[s] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
    endtask

    task automatic xfer(input int s, input logic [63:0] k, input logic [63:0] c,
                        input logic [63:0] e, input int hold);
        int n;
        sel = s;
        ky[s] = k;
        ct[s] = c;
        iv[s] = 1'b1;
        n = 0;
        while (ir[s] !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("accept_ready", 64'(ir[s]), 64'd1);
        expq.push_back(e);
        tick();
        iv[s] = 1'b0;
        ky[s] = {$urandom, $urandom};
        ct[s] = {$urandom, $urandom};
        wait_ov(s, 16 >> s);
        repeat (hold) begin
            tick();
            chk("hold_valid", 64'(ov[s]), 64'd1);
            chk("hold_pt", pt[s], e);
            chk("hold_in_ready", 64'(ir[s]), 64'd0);
        end
        ordy[s] = 1'b1;
        #1;
        chk("ready_release", 64'(ir[s]), 64'd1);
        tick();
        ordy[s] = 1'b0;
        chk("valid_drop", 64'(ov[s]), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] k, p, c;
        logic        seen;
        int          n;

        vt[0] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF};
        vt[1] = '{64'h0000000000000000, 64'h8CA64DE9C1B123A7, 64'h0000000000000000};
        vt[2] = '{64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF};
        vt[3] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787};
        vt[4] = '{64'h0123456789ABCDEF, 64'h3FA40E8A984D4815, 64'h4E6F772069732074};
        vt[5] = '{64'hECCBA8866443200E, 64'h7A17ECABF0F54BFA, 64'hFEDCBA9876543210};
        vt[6] = '{64'hF1CD6DCD1592F28C, 64'hFFFFFFFFFFFFFFFF, 64'h7878787878787878};

        for (int s = 0; s < NU; s++) begin
            iv[s] = 1'b0;
            ordy[s] = 1'b0;
            ct[s] = '0;
            ky[s] = '0;
        end

        tick();
        tick();
        for (int s = 0; s < NU; s++) begin
            sel = s;
            chk("rst_out_valid", 64'(ov[s]), 64'd0);
            chk("rst_busy", 64'(bz[s]), 64'd0);
            chk("rst_plaintext", pt[s], 64'd0);
            chk("rst_in_ready", 64'(ir[s]), 64'd1);
        end
        sel = 0;
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            chk("model_kat", enc(vt[v].key, vt[v].pt), vt[v].ct);
            for (int s = 0; s < NU; s++) xfer(s, vt[v].key, vt[v].ct, vt[v].pt, v % 3);
        end

        // Back-to-back: held output, producer waiting, accept on the release edge.
        sel = 0;
        ky[0] = vt[0].key;
        ct[0] = vt[0].ct;
        iv[0] = 1'b1;
        chk("b2b_ready", 64'(ir[0]), 64'd1);
        expq.push_back(vt[0].pt);
        tick();
        ky[0] = vt[1].key;
        ct[0] = vt[1].ct;
        chk("b2b_busy", 64'(bz[0]), 64'd1);
        chk("b2b_busy_ready", 64'(ir[0]), 64'd0);
        wait_ov(0, 16);
        repeat (5) begin
            tick();
            chk("b2b_hold_valid", 64'(ov[0]), 64'd1);
            chk("b2b_hold_pt", pt[0], vt[0].pt);
            chk("b2b_hold_ready", 64'(ir[0]), 64'd0);
        end
        ordy[0] = 1'b1;
        #1;
        chk("b2b_release_ready", 64'(ir[0]), 64'd1);
        expq.push_back(vt[1].pt);
        tick();
        ordy[0] = 1'b0;
        iv[0] = 1'b0;
        chk("b2b_restart_valid", 64'(ov[0]), 64'd0);
        chk("b2b_restart_busy", 64'(bz[0]), 64'd1);
        wait_ov(0, 16);
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;

        // Reset during round 7 aborts the block.
        ky[0] = vt[0].key;
        ct[0] = vt[0].ct;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (6) tick();
        chk("abort_busy", 64'(bz[0]), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_out_valid", 64'(ov[0]), 64'd0);
        chk("abort_plaintext", pt[0], 64'd0);
        chk("abort_busy_clr", 64'(bz[0]), 64'd0);
        chk("abort_in_ready", 64'(ir[0]), 64'd1);
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen = seen | ov[0];
        end
        chk("abort_no_output", 64'(seen), 64'd0);
        xfer(0, vt[0].key, vt[0].ct, vt[0].pt, 1);

        for (int s = 0; s < NU; s++) begin
            for (int i = 0; i < 40; i++) begin
                k = {$urandom, $urandom};
                p = {$urandom, $urandom};
                c = enc(k, p);
                n = $urandom_range(0, 2);
                xfer(s, k, c, p, n);
            end
        end

        tick();
        chk("sb_drained", 64'(expq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
